// File: rtl/chan_mailbox.sv
// Single-word channel mailbox on the CPU message bus: a small tagged table of channels,
// filled by CHAN_SET writes (completed by a thread-address message) and drained by reads.
module chan_mailbox #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int MSG_W     = 8,
   parameter int DEPTH     = 4,
   parameter int REPLY_CYC = 2,
   parameter int TA_WAIT   = 3,
   parameter logic [MSG_W-1:0] CPU_R_CHAN_SET        = MSG_W'('h11),
   parameter logic [MSG_W-1:0] CPU_R_THREAD_ADDRESS  = MSG_W'('h12),
   parameter logic [MSG_W-1:0] CPU_R_CHAN_RES_WR     = MSG_W'('h13),
   parameter logic [MSG_W-1:0] CPU_R_CHAN_NO_RESULTS = MSG_W'('h14)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [MSG_W-1:0]  msg_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic              strb_in,
   output logic [MSG_W-1:0]  msg_out,
   output logic [ADDR_W-1:0] addr_out,
   output logic [DATA_W-1:0] data_out,
   output logic [ADDR_W-1:0] thread_out,
   output logic              busy,
   output logic [4:0]        used
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT_TA, S_REPLY} state_t;

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [MSG_W-1:0]    msg_out_q, msg_out_d;
   logic [ADDR_W-1:0]   addr_out_q, addr_out_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic [ADDR_W-1:0]   thread_out_q, thread_out_d;
   logic [4:0]          used_q, used_d;

   logic [DEPTH-1:0]    valid_q;
   logic [ADDR_W-1:0]   tag_q  [DEPTH];
   logic [DATA_W-1:0]   word_q [DEPTH];
   logic [ADDR_W-1:0]   wthr_q [DEPTH];

   logic [ADDR_W-1:0]   key;
   logic [DEPTH-1:0]    hit_vec;
   logic                hit, free_ok, tbl_fill, tbl_clr;
   logic [IDX_W-1:0]    hit_idx, free_idx;

   // While a write is pending, addr_in carries the thread address, so match on the latched channel.
   assign key = (state_q == S_WAIT_TA) ? wr_addr_q : addr_in;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_match
         assign hit_vec[gi] = valid_q[gi] && (tag_q[gi] == key);
      end
   endgenerate

   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      free_ok  = 1'b0;
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (!valid_q[i]) begin
            free_ok  = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      msg_out_d    = msg_out_q;
      addr_out_d   = addr_out_q;
      data_out_d   = data_out_q;
      thread_out_d = thread_out_q;
      used_d       = used_q;
      tbl_fill     = 1'b0;
      tbl_clr      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (msg_in == CPU_R_CHAN_SET) begin
               cnt_d = '0;
               if (strb_in) begin
                  wr_addr_d = addr_in;
                  wr_data_d = data_in;
                  state_d   = S_WAIT_TA;
               end else begin
                  state_d    = S_REPLY;
                  addr_out_d = addr_in;
                  if (hit) begin
                     msg_out_d    = CPU_R_CHAN_SET;
                     data_out_d   = word_q[hit_idx];
                     thread_out_d = wthr_q[hit_idx];
                     tbl_clr      = 1'b1;
                     used_d       = used_q - 5'd1;
                  end else begin
                     msg_out_d    = CPU_R_CHAN_NO_RESULTS;
                     data_out_d   = '0;
                     thread_out_d = '0;
                  end
               end
            end
         end
         S_WAIT_TA: begin
            if (msg_in == CPU_R_THREAD_ADDRESS || cnt_q == 3'(TA_WAIT - 1)) begin
               state_d      = S_REPLY;
               cnt_d        = '0;
               addr_out_d   = wr_addr_q;
               data_out_d   = '0;
               thread_out_d = '0;
               msg_out_d    = CPU_R_CHAN_NO_RESULTS;
               // An occupied channel means the previous word is unread: the writer must retry.
               if (msg_in == CPU_R_THREAD_ADDRESS && !hit && free_ok) begin
                  msg_out_d = CPU_R_CHAN_RES_WR;
                  tbl_fill  = 1'b1;
                  used_d    = used_q + 5'd1;
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_REPLY: begin
            if (cnt_q == 3'(REPLY_CYC - 1)) begin
               state_d      = S_IDLE;
               msg_out_d    = '0;
               addr_out_d   = '0;
               data_out_d   = '0;
               thread_out_d = '0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         msg_out_q    <= '0;
         addr_out_q   <= '0;
         data_out_q   <= '0;
         thread_out_q <= '0;
         used_q       <= '0;
         valid_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         msg_out_q    <= msg_out_d;
         addr_out_q   <= addr_out_d;
         data_out_q   <= data_out_d;
         thread_out_q <= thread_out_d;
         used_q       <= used_d;
         if (tbl_fill) valid_q[free_idx] <= 1'b1;
         if (tbl_clr)  valid_q[hit_idx]  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (tbl_fill) begin
         tag_q[free_idx]  <= wr_addr_q;
         word_q[free_idx] <= wr_data_q;
         wthr_q[free_idx] <= addr_in;
      end
   end

   assign msg_out    = msg_out_q;
   assign addr_out   = addr_out_q;
   assign data_out   = data_out_q;
   assign thread_out = thread_out_q;
   assign used       = used_q;
   assign busy       = (state_q != S_IDLE);

endmodule
